// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: decode hazard info, EX/MEM status and memory
// handshake in, stall/flush/req/err out of the control unit.
interface pipe_ctrl_if;
  // Decode-stage hazard information
  logic       id2cu_wb_en_i;
  logic       id2cu_mem_en_i;
  logic [4:0] id2cu_rs1_addr_i;
  logic [4:0] id2cu_rs2_addr_i;
  logic [4:0] id2cu_rd_addr_i;
  // EX / MEM status and memory handshake
  logic       ex2cu_jump_en_i;
  logic       exmem2cu_mem_vld_i;
  logic       mem2cu_ack_i;
  logic       cu_err_clr_i;
  // Control outputs
  logic       cu2mem_req_o;
  logic       cu2pc_stall_o;
  logic       cu2ifid_stall_o;
  logic       cu2ifid_flush_o;
  logic       cu2idex_stall_o;
  logic       cu2idex_flush_o;
  logic       cu2exmem_stall_o;
  logic       cu_err_o;

  // Control unit side: drives stall/flush/req/err
  modport master (
    input  id2cu_wb_en_i, id2cu_mem_en_i, id2cu_rs1_addr_i, id2cu_rs2_addr_i,
           id2cu_rd_addr_i, ex2cu_jump_en_i, exmem2cu_mem_vld_i, mem2cu_ack_i,
           cu_err_clr_i,
    output cu2mem_req_o, cu2pc_stall_o, cu2ifid_stall_o, cu2ifid_flush_o,
           cu2idex_stall_o, cu2idex_flush_o, cu2exmem_stall_o, cu_err_o
  );

  // Pipeline / memory side: supplies status, consumes control
  modport slave (
    output id2cu_wb_en_i, id2cu_mem_en_i, id2cu_rs1_addr_i, id2cu_rs2_addr_i,
           id2cu_rd_addr_i, ex2cu_jump_en_i, exmem2cu_mem_vld_i, mem2cu_ack_i,
           cu_err_clr_i,
    input  cu2mem_req_o, cu2pc_stall_o, cu2ifid_stall_o, cu2ifid_flush_o,
           cu2idex_stall_o, cu2idex_flush_o, cu2exmem_stall_o, cu_err_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage core: memory handshake with timeout,
// taken-jump flush and load-use bubble insertion. Outputs are combinational.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input logic           clk,
  input logic           rst_n,
  pipe_ctrl_if.master   cu
);

  // Counter must reach MEM_TIMEOUT-1; fewer than 2 wait cycles is meaningless
  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT >= (1 << CNT_W)) begin : gen_param_check
    $error("pipe_ctrl: MEM_TIMEOUT must be >= 2 and representable in CNT_W bits");
  end

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StErr     = 2'd2;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_load_q, ex_load_d;

  logic mem_stall;
  logic mem_req;
  logic jump_act;
  logic load_use;
  logic load_use_act;
  logic idex_flush;

  // Memory stall and request derived from FSM state and current handshake
  always_comb begin
    mem_stall = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      StRun: begin
        mem_stall = cu.exmem2cu_mem_vld_i & ~cu.mem2cu_ack_i;
        mem_req   = cu.exmem2cu_mem_vld_i;
      end
      StMemWait: begin
        mem_stall = ~cu.mem2cu_ack_i;
        mem_req   = 1'b1;
      end
      StErr: begin
        mem_stall = 1'b1;
        mem_req   = 1'b0;
      end
      default: begin
        mem_stall = 1'b0;
        mem_req   = 1'b0;
      end
    endcase
  end

  // Hazard resolution: memory stall beats jump, jump beats load-use
  always_comb begin
    // A non-zero rd can only match a non-zero rs, so x0 never creates a hazard
    load_use = ex_load_q && (ex_rd_q != 5'd0) &&
               ((ex_rd_q == cu.id2cu_rs1_addr_i) || (ex_rd_q == cu.id2cu_rs2_addr_i));
    jump_act     = cu.ex2cu_jump_en_i & ~mem_stall;
    load_use_act = load_use & ~mem_stall & ~cu.ex2cu_jump_en_i;
    idex_flush   = jump_act | load_use_act;
  end

  // FSM next state and timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (cu.exmem2cu_mem_vld_i && !cu.mem2cu_ack_i) begin
          state_d = StMemWait;
          cnt_d   = '0;
        end
      end
      StMemWait: begin
        if (cu.mem2cu_ack_i) begin
          state_d = StRun;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StErr: begin
        if (cu.cu_err_clr_i) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // EX-stage destination tracking follows ID/EX: held on stall, zeroed on bubble
  always_comb begin
    ex_rd_d   = ex_rd_q;
    ex_load_d = ex_load_q;
    if (!mem_stall) begin
      if (idex_flush) begin
        ex_rd_d   = 5'd0;
        ex_load_d = 1'b0;
      end else begin
        ex_rd_d   = cu.id2cu_rd_addr_i;
        ex_load_d = cu.id2cu_mem_en_i & cu.id2cu_wb_en_i;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      ex_rd_q   <= 5'd0;
      ex_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_rd_q   <= ex_rd_d;
      ex_load_q <= ex_load_d;
    end
  end

  // Outputs forced low while reset is asserted, independent of inputs
  always_comb begin
    cu.cu2mem_req_o     = rst_n & mem_req;
    cu.cu2pc_stall_o    = rst_n & (mem_stall | load_use_act);
    cu.cu2ifid_stall_o  = rst_n & (mem_stall | load_use_act);
    cu.cu2ifid_flush_o  = rst_n & jump_act;
    cu.cu2idex_stall_o  = rst_n & mem_stall;
    cu.cu2idex_flush_o  = rst_n & idex_flush;
    cu.cu2exmem_stall_o = rst_n & mem_stall;
    cu.cu_err_o         = rst_n & (state_q == StErr);
  end

  // Stall and flush of the same pipeline register are mutually exclusive
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(cu.cu2ifid_stall_o && cu.cu2ifid_flush_o));
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(cu.cu2idex_stall_o && cu.cu2idex_flush_o));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// behavioural model; expected outputs are queued and checked by a monitor.
module tb_pipe_ctrl;
  localparam int unsigned Timeout = 16;

  typedef struct packed {
    logic req;
    logic pc_st;
    logic ifid_st;
    logic ifid_fl;
    logic idex_st;
    logic idex_fl;
    logic exmem_st;
    logic err;
  } outs_t;

  typedef struct {
    logic       wb;
    logic       mem;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       jmp;
    logic       vld;
    logic       ack;
    logic       clr;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.MEM_TIMEOUT(Timeout), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  outs_t exp_q[$];

  // Model: memory port is either idle, waiting (with elapsed wait count) or failed
  typedef enum {MemIdle, MemWaiting, MemFailed} mem_mode_e;
  mem_mode_e  m_mode;
  int         m_waited;
  logic [4:0] m_ex_rd;
  logic       m_ex_load;

  task automatic model_reset();
    m_mode    = MemIdle;
    m_waited  = 0;
    m_ex_rd   = 5'd0;
    m_ex_load = 1'b0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{wb: 1'b0, mem: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          jmp: 1'b0, vld: 1'b0, ack: 1'b0, clr: 1'b0};
    return s;
  endfunction

  // Apply one cycle of stimulus at the negedge, queue the expected outputs, advance model
  task automatic drive(input stim_t s);
    outs_t e;
    logic  busy, jmp_eff, lu;
    bus.id2cu_wb_en_i      = s.wb;
    bus.id2cu_mem_en_i     = s.mem;
    bus.id2cu_rs1_addr_i   = s.rs1;
    bus.id2cu_rs2_addr_i   = s.rs2;
    bus.id2cu_rd_addr_i    = s.rd;
    bus.ex2cu_jump_en_i    = s.jmp;
    bus.exmem2cu_mem_vld_i = s.vld;
    bus.mem2cu_ack_i       = s.ack;
    bus.cu_err_clr_i       = s.clr;

    busy = (m_mode == MemIdle && s.vld && !s.ack) || (m_mode == MemWaiting && !s.ack) ||
           (m_mode == MemFailed);
    jmp_eff = !busy && s.jmp;
    lu = !busy && !s.jmp && m_ex_load && m_ex_rd != 5'd0 &&
         (m_ex_rd == s.rs1 || m_ex_rd == s.rs2);

    e.req      = (m_mode == MemIdle && s.vld) || (m_mode == MemWaiting);
    e.pc_st    = busy || lu;
    e.ifid_st  = busy || lu;
    e.ifid_fl  = jmp_eff;
    e.idex_st  = busy;
    e.idex_fl  = jmp_eff || lu;
    e.exmem_st = busy;
    e.err      = (m_mode == MemFailed);
    exp_q.push_back(e);

    if (!busy) begin
      if (jmp_eff || lu) begin
        m_ex_rd   = 5'd0;
        m_ex_load = 1'b0;
      end else begin
        m_ex_rd   = s.rd;
        m_ex_load = s.mem && s.wb;
      end
    end
    case (m_mode)
      MemIdle: if (s.vld && !s.ack) begin
        m_mode   = MemWaiting;
        m_waited = 0;
      end
      MemWaiting: begin
        if (s.ack) m_mode = MemIdle;
        else begin
          m_waited++;
          if (m_waited == Timeout) m_mode = MemFailed;
        end
      end
      default: if (s.clr) begin
        m_mode   = MemIdle;
        m_waited = 0;
      end
    endcase
    @(negedge clk);
  endtask

  // Hold reset for one cycle with a memory op presented; all outputs must be low
  task automatic pulse_reset();
    rst_n = 1'b0;
    bus.exmem2cu_mem_vld_i = 1'b1;
    bus.ex2cu_jump_en_i    = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare each queued expectation against the live outputs mid-cycle
  initial begin
    string names [8];
    outs_t act, e;
    names = '{"req", "pc_stall", "ifid_stall", "ifid_flush", "idex_stall", "idex_flush",
              "exmem_stall", "err"};
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = '{req: bus.cu2mem_req_o, pc_st: bus.cu2pc_stall_o,
                ifid_st: bus.cu2ifid_stall_o, ifid_fl: bus.cu2ifid_flush_o,
                idex_st: bus.cu2idex_stall_o, idex_fl: bus.cu2idex_flush_o,
                exmem_st: bus.cu2exmem_stall_o, err: bus.cu_err_o};
        for (int b = 0; b < 8; b++) begin
          n_tests++;
          if (act[7-b] !== e[7-b]) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %b, expected %b", names[b], $time, act[7-b],
                     e[7-b]);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    ack_pct;
    rst_n = 1'b0;
    s = idle();
    bus.id2cu_wb_en_i      = 1'b0;
    bus.id2cu_mem_en_i     = 1'b0;
    bus.id2cu_rs1_addr_i   = 5'd0;
    bus.id2cu_rs2_addr_i   = 5'd0;
    bus.id2cu_rd_addr_i    = 5'd0;
    bus.ex2cu_jump_en_i    = 1'b0;
    bus.exmem2cu_mem_vld_i = 1'b0;
    bus.mem2cu_ack_i       = 1'b0;
    bus.cu_err_clr_i       = 1'b0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Load-use on x5: one bubble, then the held instruction proceeds
    s = idle(); s.wb = 1; s.mem = 1; s.rd = 5'd5; drive(s);
    s = idle(); s.rs1 = 5'd5; s.rd = 5'd6; s.wb = 1; drive(s);
    drive(s);
    drive(idle());

    // Load to x0 never creates a hazard
    s = idle(); s.wb = 1; s.mem = 1; s.rd = 5'd0; drive(s);
    s = idle(); s.rs1 = 5'd0; s.rs2 = 5'd0; drive(s);

    // Memory op acknowledged after three waiting cycles
    s = idle(); s.vld = 1; drive(s); drive(s); drive(s);
    s.ack = 1; drive(s);
    drive(idle());

    // Jump held through a memory wait flushes only on the ack cycle
    s = idle(); s.vld = 1; s.jmp = 1; drive(s); drive(s);
    s.ack = 1; drive(s);
    drive(idle());

    // Timeout into error, then clear
    s = idle(); s.vld = 1;
    for (int i = 0; i < Timeout + 3; i++) drive(s);
    s.clr = 1; drive(s);
    drive(idle()); drive(idle());

    // Reset in the middle of a wait, then a full timeout must take the whole budget
    s = idle(); s.vld = 1;
    for (int i = 0; i < 5; i++) drive(s);
    pulse_reset();
    for (int i = 0; i < Timeout + 2; i++) drive(s);
    s.clr = 1; drive(s);

    // Randomized traffic with varying memory latency
    for (int blk = 0; blk < 15; blk++) begin
      case (blk % 3)
        0:       ack_pct = 70;
        1:       ack_pct = 30;
        default: ack_pct = 3;
      endcase
      for (int i = 0; i < 200; i++) begin
        logic [4:0] regs [5];
        regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5};
        s.wb  = 1'($urandom_range(0, 1));
        s.mem = 1'($urandom_range(0, 1));
        s.rs1 = regs[$urandom_range(0, 4)];
        s.rs2 = regs[$urandom_range(0, 4)];
        s.rd  = regs[$urandom_range(0, 4)];
        s.jmp = ($urandom_range(0, 5) == 0);
        s.vld = ($urandom_range(0, 2) == 0);
        s.ack = ($urandom_range(0, 99) < ack_pct);
        s.clr = ($urandom_range(0, 9) == 0);
        drive(s);
      end
    end

    drive(idle());
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
